// File: rtl/seg_scroller.sv
// seg_scroller
//   Buffered message engine for a single 7-segment display. A small glyph
//   buffer is filled through a write port. Once started, the engine steps
//   through the first len entries at a programmable rate. Each entry is
//   shown through a hex decode table, and bit 4 of the entry drives the
//   decimal point. Playback either loops or runs once and then parks in DONE.
//   The pause input freezes stepping.
//
// Optional build macro: RAW_SEG_EN
//   When defined, entries are 9 bits wide. An entry with bit 8 set drives
//   segments[7:0] directly from entry[7:0] and bypasses the decode table.
//   When undefined, entries are 5 bits wide and wr_data[8:5] is ignored.
//
// Parameters
//   ADDR_W      buffer address width, DEPTH = 2**ADDR_W entries
//   PRESCALE_W  width of the step prescaler and of the rate input
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset; also clears the buffer
//   wr_en     buffer write strobe
//   wr_addr   buffer write address
//   wr_data   glyph entry: [3:0] hex code, [4] dp, [8:5] raw segments
//   start     one-cycle pulse that latches len/oneshot and (re)starts playback
//   len       message length 1..DEPTH; 0 stops and returns to IDLE
//   oneshot   1 = play once then DONE, 0 = loop
//   pause     level input that freezes stepping
//   rate      step period minus one, in clk cycles
//   segments  {dp, g, f, e, d, c, b, a}, active high, registered
//   pos       index of the displayed entry, registered
//   busy      high while in RUN
//   done      high while in DONE

module seg_scroller #(
  parameter int ADDR_W     = 3,
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [8:0]            wr_data,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  input  logic                  oneshot,
  input  logic                  pause,
  input  logic [PRESCALE_W-1:0] rate,
  output logic [7:0]            segments,
  output logic [ADDR_W-1:0]     pos,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef RAW_SEG_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 5;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [ENTRY_W-1:0]      glyph_mem [DEPTH];
  logic [PRESCALE_W-1:0]   prescaler;
  logic [ADDR_W:0]         len_q;
  logic                    oneshot_q;
  logic [ADDR_W:0]         last_idx;
  logic [ADDR_W:0]         len_clamped;
  logic                    at_last;

`ifndef RAW_SEG_EN
  // The raw-segment bits have no use without the raw path.
  logic unused_raw_bits;
  assign unused_raw_bits = ^wr_data[8:5];
`endif

  // Hex code to segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Full 8-bit display pattern for one stored entry.
  function automatic logic [7:0] glyph(input logic [ENTRY_W-1:0] entry);
    logic [7:0] s;
    s = {entry[4], hex7(entry[3:0])};
`ifdef RAW_SEG_EN
    if (entry[8]) s = entry[7:0];
`endif
    return s;
  endfunction

  // The length is clamped so that an oversized len plays the whole buffer.
  // The last index is compared at full width, so a zero len_q can never
  // alias to a valid position.
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_idx    = len_q - (ADDR_W + 1)'(1);
  assign at_last     = ({1'b0, pos} == last_idx);

  // Glyph buffer. Writes are accepted in every state. Reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        glyph_mem[i] <= '0;
      end
    end else if (wr_en) begin
      glyph_mem[wr_addr] <= wr_data[ENTRY_W-1:0];
    end
  end

  // Playback FSM. Segments follow the current state and position, so a
  // glyph (or a rewrite of the shown entry) reaches the pins one edge after
  // the state/position/buffer change that selects it. A start request
  // overrides any stepping on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      segments  <= 8'h00;
      pos       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      prescaler <= '0;
      len_q     <= '0;
      oneshot_q <= 1'b0;
    end else begin
      if (state == RUN) begin
        segments <= glyph(glyph_mem[pos]);
      end else begin
        segments <= 8'h00;
      end

      if (start) begin
        if (len == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pos   <= '0;
        end else begin
          len_q     <= len_clamped;
          oneshot_q <= oneshot;
          pos       <= '0;
          prescaler <= '0;
          state     <= RUN;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (!pause) begin
              // An exact match only: a prescaler already past a newly
              // lowered rate runs on and wraps before it matches.
              if (prescaler == rate) begin
                prescaler <= '0;
                if (at_last) begin
                  if (oneshot_q) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end else begin
                    pos <= '0;
                  end
                end else begin
                  pos <= pos + ADDR_W'(1);
                end
              end else begin
                prescaler <= prescaler + PRESCALE_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scroller.sv
// tb_seg_scroller
//   Self-checking bench for seg_scroller with default parameters. A table of
//   per-cycle vectors covers looping, the len = 0 stop, one-shot completion
//   and restart. Hand-written sequences cover pause, a live rewrite of the
//   shown entry, len clamping, reset mid-run and the raw-segment entry.
//   Inputs change and outputs are sampled on the falling clock edge.

module tb_seg_scroller;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        start;
  logic [3:0]  len;
  logic        oneshot;
  logic        pause;
  logic [23:0] rate;
  logic [7:0]  segments;
  logic [2:0]  pos;
  logic        busy;
  logic        done;

  int total;
  int bad;

  typedef struct {
    logic        start;
    logic [3:0]  len;
    logic        oneshot;
    logic        pause;
    logic [23:0] rate;
    logic [7:0]  exp_seg;
    logic [2:0]  exp_pos;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  seg_scroller #(.ADDR_W(3), .PRESCALE_W(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .len      (len),
    .oneshot  (oneshot),
    .pause    (pause),
    .rate     (rate),
    .segments (segments),
    .pos      (pos),
    .busy     (busy),
    .done     (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic [3:0] ln, input logic os,
                              input logic pz, input logic [23:0] rt,
                              input logic [7:0] sg, input logic [2:0] ps,
                              input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.len = ln; v.oneshot = os; v.pause = pz; v.rate = rt;
    v.exp_seg = sg; v.exp_pos = ps; v.exp_busy = bz; v.exp_done = dn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    start   = v.start;
    len     = v.len;
    oneshot = v.oneshot;
    pause   = v.pause;
    rate    = v.rate;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_seg,
                             input logic [2:0] e_pos, input logic e_busy,
                             input logic e_done);
    total++;
    if (segments !== e_seg || pos !== e_pos || busy !== e_busy || done !== e_done) begin
      bad++;
      $display("[TB] FAIL %s: got seg=%h pos=%0d busy=%b done=%b, want seg=%h pos=%0d busy=%b done=%b",
               name, segments, pos, busy, done, e_seg, e_pos, e_busy, e_done);
    end
  endtask

  task automatic writeEntry(input logic [2:0] a, input logic [8:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // One start pulse, followed by one edge.
  task automatic startRun(input logic [3:0] ln, input logic os, input logic [23:0] rt);
    start   = 1'b1;
    len     = ln;
    oneshot = os;
    rate    = rt;
    tick();
    start   = 1'b0;
  endtask

  logic [7:0] play_seg [8];
  logic [7:0] raw_exp;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    len     = '0;
    oneshot = 1'b0;
    pause   = 1'b0;
    rate    = '0;

    play_seg[0] = 8'h06; play_seg[1] = 8'h5B; play_seg[2] = 8'hF9; play_seg[3] = 8'h66;
    play_seg[4] = 8'h6D; play_seg[5] = 8'h7D; play_seg[6] = 8'h07; play_seg[7] = 8'h7F;

    // Loop, len 4, rate 2: each glyph is held 3 cycles and lags pos by one edge.
    vecs.push_back(mk(1, 4, 0, 0, 2, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h5B, 1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h5B, 1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h5B, 2, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h4F, 2, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h4F, 2, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h4F, 3, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h66, 3, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h66, 3, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h66, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 0, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h06, 1, 1, 0));
    vecs.push_back(mk(0, 4, 0, 0, 2, 8'h5B, 1, 1, 0));
    // start with len 0: back to IDLE, then blank.
    vecs.push_back(mk(1, 0, 0, 0, 2, 8'h5B, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 8'h00, 0, 0, 0));
    // One-shot, rate 0.
    vecs.push_back(mk(1, 4, 1, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h06, 1, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h5B, 2, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h4F, 3, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h66, 3, 0, 1));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h00, 3, 0, 1));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h00, 3, 0, 1));
    // Restart from DONE.
    vecs.push_back(mk(1, 4, 1, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h06, 1, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h5B, 2, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h4F, 3, 1, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h66, 3, 0, 1));
    vecs.push_back(mk(0, 4, 1, 0, 0, 8'h00, 3, 0, 1));

    tick();
    tick();
    checkOutput("reset_state", 8'h00, 0, 0, 0);
    reset = 1'b0;

    writeEntry(3'd0, 9'h001);
    writeEntry(3'd1, 9'h002);
    writeEntry(3'd2, 9'h003);
    writeEntry(3'd3, 9'h004);
    writeEntry(3'd4, 9'h005);
    writeEntry(3'd5, 9'h006);
    writeEntry(3'd6, 9'h007);
    writeEntry(3'd7, 9'h008);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_seg, vecs[i].exp_pos,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end
    start = 1'b0;

    // Pause mid-glyph at rate 4: prescaler is 2 when pause rises.
    startRun(4'd4, 1'b0, 24'd4);
    checkOutput("pause_start", 8'h00, 0, 1, 0);
    tick();
    tick();
    checkOutput("pause_pre", 8'h06, 0, 1, 0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("pause_hold%0d", i), 8'h06, 0, 1, 0);
    end
    pause = 1'b0;
    tick();
    checkOutput("pause_rel1", 8'h06, 0, 1, 0);
    tick();
    checkOutput("pause_rel2", 8'h06, 0, 1, 0);
    tick();
    checkOutput("pause_step", 8'h06, 1, 1, 0);
    tick();
    checkOutput("pause_next", 8'h5B, 1, 1, 0);

    // Rewrite the displayed entry 2 with E plus dp.
    startRun(4'd4, 1'b0, 24'd20);
    for (int i = 0; i < 43; i++) tick();
    checkOutput("live_before", 8'h4F, 2, 1, 0);
    writeEntry(3'd2, 9'h01E);
    checkOutput("live_edge1", 8'h4F, 2, 1, 0);
    tick();
    checkOutput("live_edge2", 8'hF9, 2, 1, 0);

    // len 15 clamps to the 8-entry buffer.
    startRun(4'd15, 1'b0, 24'd0);
    checkOutput("len15_start", 8'hF9, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("len15_%0d", k), play_seg[(k - 1) % 8], 3'(k % 8), 1, 0);
    end

    // Reset during RUN clears outputs and the buffer.
    reset = 1'b1;
    tick();
    checkOutput("reset_run", 8'h00, 0, 0, 0);
    reset = 1'b0;
    startRun(4'd8, 1'b0, 24'd0);
    checkOutput("clr_start", 8'h00, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("clr_%0d", k), 8'h3F, 3'(k % 8), 1, 0);
    end

    // Raw-segment entry, single-entry loop.
`ifdef RAW_SEG_EN
    raw_exp = 8'hA5;
`else
    raw_exp = 8'h6D;
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    writeEntry(3'd0, 9'h1A5);
    startRun(4'd1, 1'b0, 24'd0);
    checkOutput("raw_start", 8'h00, 0, 1, 0);
    tick();
    checkOutput("raw_1", raw_exp, 0, 1, 0);
    tick();
    checkOutput("raw_2", raw_exp, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scroller.md
Name: seg_scroller

Overview:
- Parametrised successor to the single-digit 7-segment decode path: a buffered message engine that steps a stored glyph sequence onto one 7-segment display at a programmable rate.
- Holds 2**ADDR_W glyph entries written through a simple write port.
- Decodes each entry through a built-in hex table, with a decimal point, and supports loop and one-shot modes with pause.
- Sits between the user-input / IO logic and the display pins.

Parameters:
- ADDR_W, 3, buffer address width; DEPTH = 2**ADDR_W entries.
- PRESCALE_W, 24, width of the step-rate prescaler and of the rate input.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for the glyph buffer.
- wr_addr  input  ADDR_W  buffer write address.
- wr_data  input  9  glyph entry. [3:0] = hex code, [4] = decimal point, [8:5] used only with RAW_SEG_EN.
- start  input  1  single-cycle pulse; latches len/oneshot and (re)starts playback.
- len  input  ADDR_W+1  message length, 1..DEPTH.
- oneshot  input  1  1 = play once then stop; 0 = loop.
- pause  input  1  level; freezes stepping while high.
- rate  input  PRESCALE_W  step period minus one, in clk cycles.
- segments  output  8  bit0 = a (top) ... bit6 = g (middle), bit7 = dp; active-high; registered.
- pos  output  ADDR_W  index of the displayed entry; registered.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset: state IDLE; segments = 0x00, pos = 0, busy = 0, done = 0, prescaler = 0, len_q = 0; every buffer entry cleared to 0.
- Buffer writes: wr_en high at an edge writes wr_data to entry wr_addr.
  - Writes are accepted in every state, including while that entry is displayed.
  - A write to the displayed entry appears on segments at the second edge after wr_en is sampled.
- States:
  - IDLE: segments = 0x00.
  - RUN: segments <= decode(buf[pos]) every edge.
  - DONE: segments = 0x00, done = 1.
- start handling, taking priority over stepping in any state:
  - len = 0: go to IDLE and clear pos.
  - Otherwise: len_q = min(len, DEPTH), oneshot_q = oneshot, pos = 0, prescaler = 0, state = RUN.
  - First glyph appears on segments one edge after the RUN entry edge.
- Stepping in RUN:
  - Stepping only happens in RUN with pause = 0.
  - Prescaler increments each edge. When prescaler == rate, the prescaler clears and pos advances, so the step period is rate+1 cycles.
  - rate = 0 advances every cycle.
- pos wrap:
  - At pos == len_q-1, a step sends pos to 0 when looping.
  - When oneshot_q = 1, the step instead goes to DONE with pos held.
  - len_q = 1 in loop mode holds pos at 0.
- pause: holds both prescaler and pos; on release, counting resumes from the held value.
- rate changing mid-run takes effect immediately. If the prescaler is already above the new rate, it wraps at 2**PRESCALE_W-1 before matching; no extra detection is required.
- Hex table (segments[6:0]):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - segments[7] = entry[4].
- Outputs: busy = (state == RUN) and done = (state == DONE), both registered together with state.
- Reset mid-run returns to the reset state on that edge; the buffer is cleared.

Optional Feature:
- Macro: RAW_SEG_EN.
- Defined:
  - Entries are stored as 9 bits.
  - With wr_data[8] = 1, segments = wr_data[7:0] directly, with no decode.
  - With wr_data[8] = 0, entries are decoded as normal.
- Undefined:
  - Entries are stored as 5 bits (wr_data[4:0]).
  - wr_data[8:5] is ignored, and the raw path is absent from the RTL.

Test Plan:
- Load entries 0..3 with codes 1,2,3,4 and dp = 0, then start with len = 4, rate = 2, oneshot = 0:
  - segments sequence 06, 5B, 4F, 66, 06...
  - Each glyph is held 3 cycles; pos wraps 3->0.
  - busy = 1 and done = 0 throughout.
- Same buffer with oneshot = 1, rate = 0:
  - segments 06, 5B, 4F, 66, one cycle each.
  - Then DONE: segments = 00, done = 1, pos = 3.
  - start re-enters RUN at pos 0.
- Run with rate = 4 and assert pause for 10 cycles mid-glyph:
  - pos and glyph are frozen.
  - After release, the remaining step cycles complete, with no lost or extra step.
- Write entry 2 = 0x1E (E with dp) while pos = 2 is displayed:
  - segments changes to F9 two edges after the write.
- Boundaries:
  - start with len = 0 -> IDLE, segments = 00.
  - start with len = 15 and ADDR_W = 3 -> plays 8 entries.
  - reset asserted during RUN -> all outputs 0 next edge, and all buffer entries read back as glyph 3F.
- RAW_SEG_EN defined: write entry 0 = 0x1A5 and start with len = 1 -> segments = A5. With the macro undefined, the same write -> segments = 6D.
